// File: rtl/write_resp_router_1_2_if.sv
// AW-gating and B-return signal bundle for the 2:1 write response router.
// The slave modport is the router's view; master is the surrounding fabric or bench.
interface write_resp_router_1_2_if #(
    parameter int Cnt_width = 3
);
    logic                 Selected_Slave;
    logic                 Sel_S_AXI_awvalid;
    logic                 M_AXI_awready;
    logic                 M_AXI_awvalid;
    logic                 Sel_S_AXI_awready;
    logic [1:0]           M_AXI_bresp;
    logic                 M_AXI_bvalid;
    logic                 M_AXI_bready;
    logic [1:0]           S00_AXI_bresp;
    logic                 S00_AXI_bvalid;
    logic                 S00_AXI_bready;
    logic [1:0]           S01_AXI_bresp;
    logic                 S01_AXI_bvalid;
    logic                 S01_AXI_bready;
    logic [Cnt_width-1:0] Outstanding_cnt;
    logic                 Resp_unexpected;

    modport slave (
        input  Selected_Slave, Sel_S_AXI_awvalid, M_AXI_awready,
        input  M_AXI_bresp, M_AXI_bvalid, S00_AXI_bready, S01_AXI_bready,
        output M_AXI_awvalid, Sel_S_AXI_awready, M_AXI_bready,
        output S00_AXI_bresp, S00_AXI_bvalid, S01_AXI_bresp, S01_AXI_bvalid,
        output Outstanding_cnt, Resp_unexpected
    );

    modport master (
        output Selected_Slave, Sel_S_AXI_awvalid, M_AXI_awready,
        output M_AXI_bresp, M_AXI_bvalid, S00_AXI_bready, S01_AXI_bready,
        input  M_AXI_awvalid, Sel_S_AXI_awready, M_AXI_bready,
        input  S00_AXI_bresp, S00_AXI_bvalid, S01_AXI_bresp, S01_AXI_bvalid,
        input  Outstanding_cnt, Resp_unexpected
    );
endinterface

// File: rtl/write_resp_router_1_2.sv
// Write return path of the 2:1 interconnect: in-order owner FIFO filled on AW
// handshakes, B channel steered to the owner at the FIFO head, AW throttled when full.
module write_resp_router_1_2 #(
    parameter int Outstanding_Depth = 4,
    parameter int Cnt_width         = $clog2(Outstanding_Depth) + 1
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    write_resp_router_1_2_if.slave        bus
);
    localparam int PTR_W = $clog2(Outstanding_Depth);

    logic [Outstanding_Depth-1:0] owner;
    logic [PTR_W-1:0]             wr_ptr, rd_ptr;
    logic [Cnt_width-1:0]         cnt;
    logic                         unexp;
    logic                         full, empty, head, push, pop;

    assign full  = (cnt == Cnt_width'(Outstanding_Depth));
    assign empty = (cnt == '0);
    assign head  = owner[rd_ptr];

    // Gating uses the registered count only, so a same-cycle pop never frees a slot
    // and there is no path from the masters' bready into the AW channel.
    assign bus.M_AXI_awvalid     = bus.Sel_S_AXI_awvalid & ~full;
    assign bus.Sel_S_AXI_awready = bus.M_AXI_awready & ~full;

    assign push = bus.M_AXI_awvalid & bus.M_AXI_awready;
    assign pop  = bus.M_AXI_bvalid & bus.M_AXI_bready;

    always_comb begin
        bus.M_AXI_bready   = 1'b0;
        bus.S00_AXI_bvalid = 1'b0;
        bus.S00_AXI_bresp  = 2'b00;
        bus.S01_AXI_bvalid = 1'b0;
        bus.S01_AXI_bresp  = 2'b00;
        if (!empty) begin
            if (!head) begin
                bus.S00_AXI_bvalid = bus.M_AXI_bvalid;
                bus.S00_AXI_bresp  = bus.M_AXI_bresp;
                bus.M_AXI_bready   = bus.S00_AXI_bready;
            end else begin
                bus.S01_AXI_bvalid = bus.M_AXI_bvalid;
                bus.S01_AXI_bresp  = bus.M_AXI_bresp;
                bus.M_AXI_bready   = bus.S01_AXI_bready;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            owner  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            unexp  <= 1'b0;
        end else begin
            if (push) begin
                owner[wr_ptr] <= bus.Selected_Slave;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + Cnt_width'(1);
                2'b01:   cnt <= cnt - Cnt_width'(1);
                default: cnt <= cnt;
            endcase
            // A response with nothing outstanding is never consumed; flag it until reset.
            if (bus.M_AXI_bvalid && empty)
                unexp <= 1'b1;
        end
    end

    assign bus.Outstanding_cnt = cnt;
    assign bus.Resp_unexpected = unexp;
endmodule

// File: tb/tb_write_resp_router_1_2.sv
// Scenario bench for write_resp_router_1_2: owner scoreboard filled on AW
// acceptance, drained and compared as B responses are routed.
module tb_write_resp_router_1_2;
    logic ACLK = 1'b0;
    logic ARESET;
    int   errors = 0;
    int   checks = 0;
    logic sb[$];

    always #5 ACLK = ~ACLK;

    write_resp_router_1_2_if #(.Cnt_width(3)) bus();

    write_resp_router_1_2 #(.Outstanding_Depth(4)) dut (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .bus   (bus)
    );

    task automatic idle_inputs();
        bus.Selected_Slave    = 1'b0;
        bus.Sel_S_AXI_awvalid = 1'b0;
        bus.M_AXI_awready     = 1'b0;
        bus.M_AXI_bresp       = 2'b00;
        bus.M_AXI_bvalid      = 1'b0;
        bus.S00_AXI_bready    = 1'b0;
        bus.S01_AXI_bready    = 1'b0;
    endtask

    // Offer one AW from master m; returns just after a negedge with awvalid dropped.
    task automatic drive_aw(input logic m);
        bit ok = 0;
        bus.Selected_Slave    = m;
        bus.Sel_S_AXI_awvalid = 1'b1;
        bus.M_AXI_awready     = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (bus.M_AXI_awvalid && bus.Sel_S_AXI_awready) ok = 1;
            @(posedge ACLK);
            @(negedge ACLK);
        end
        bus.Sel_S_AXI_awvalid = 1'b0;
        bus.M_AXI_awready     = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL aw_accept_timeout: master=%0d not accepted within 20 cycles", m);
        end else
            sb.push_back(m);
    endtask

    // Present one B beat with both masters ready; capture routed outputs before the edge.
    task automatic drive_b(input logic [1:0] resp, output logic v0, output logic v1,
                           output logic [1:0] r0, output logic [1:0] r1);
        bus.M_AXI_bvalid   = 1'b1;
        bus.M_AXI_bresp    = resp;
        bus.S00_AXI_bready = 1'b1;
        bus.S01_AXI_bready = 1'b1;
        #1;
        v0 = bus.S00_AXI_bvalid; v1 = bus.S01_AXI_bvalid;
        r0 = bus.S00_AXI_bresp;  r1 = bus.S01_AXI_bresp;
        @(posedge ACLK);
        @(negedge ACLK);
        bus.M_AXI_bvalid   = 1'b0;
        bus.S00_AXI_bready = 1'b0;
        bus.S01_AXI_bready = 1'b0;
    endtask

    task automatic check_b(input string name, input logic [1:0] resp);
        logic v0, v1, exp;
        logic [1:0] r0, r1, got;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        exp = sb.pop_front();
        drive_b(resp, v0, v1, r0, r1);
        checks++;
        if ({v1, v0} !== (exp ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL %s_route: s01v,s00v=%b%b expected owner %0d", name, v1, v0, exp);
        end
        got = exp ? r1 : r0;
        checks++;
        if (got !== resp || (exp ? r0 : r1) !== 2'b00) begin
            errors++;
            $display("FAIL %s_bresp: got %b other %b expected %b/00", name, got, exp ? r0 : r1, resp);
        end
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        idle_inputs();
        repeat (2) @(negedge ACLK);
        #1;
        checks++;
        if (bus.Outstanding_cnt !== 3'd0 || bus.Resp_unexpected !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d unexp=%b expected 0/0", bus.Outstanding_cnt, bus.Resp_unexpected);
        end
        checks++;
        if ({bus.S00_AXI_bvalid, bus.S01_AXI_bvalid, bus.M_AXI_bready, bus.S00_AXI_bresp, bus.S01_AXI_bresp} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: v0=%b v1=%b brdy=%b r0=%b r1=%b expected all 0",
                     bus.S00_AXI_bvalid, bus.S01_AXI_bvalid, bus.M_AXI_bready, bus.S00_AXI_bresp, bus.S01_AXI_bresp);
        end
        ARESET = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_single();
        // AW cycle: B must stay blocked while the FIFO is still empty.
        bus.Selected_Slave = 1'b0; bus.Sel_S_AXI_awvalid = 1'b1; bus.M_AXI_awready = 1'b1;
        bus.S00_AXI_bready = 1'b1; bus.S01_AXI_bready = 1'b1;
        #1;
        checks++;
        if (bus.M_AXI_bready !== 1'b0 || bus.M_AXI_awvalid !== 1'b1) begin
            errors++;
            $display("FAIL single_aw_cycle: bready=%b awvalid=%b expected 0/1", bus.M_AXI_bready, bus.M_AXI_awvalid);
        end
        @(posedge ACLK); @(negedge ACLK);
        idle_inputs();
        sb.push_back(1'b0);
        checks++;
        if (bus.Outstanding_cnt !== 3'd1) begin
            errors++;
            $display("FAIL single_cnt_after_aw: got %0d expected 1", bus.Outstanding_cnt);
        end
        @(negedge ACLK);
        check_b("single", 2'b00);
        checks++;
        if (bus.Outstanding_cnt !== 3'd0) begin
            errors++;
            $display("FAIL single_cnt_after_b: got %0d expected 0", bus.Outstanding_cnt);
        end
    endtask

    task automatic test_order();
        logic       ms[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [1:0] rs[4] = '{2'b00, 2'b10, 2'b00, 2'b11};
        foreach (ms[i]) drive_aw(ms[i]);
        foreach (rs[i]) check_b($sformatf("order%0d", i), rs[i]);
    endtask

    task automatic test_full();
        logic exp;
        for (int i = 0; i < 4; i++) drive_aw(logic'(i % 2));
        checks++;
        if (bus.Outstanding_cnt !== 3'd4) begin
            errors++;
            $display("FAIL full_cnt: got %0d expected 4", bus.Outstanding_cnt);
        end
        bus.Selected_Slave = 1'b1; bus.Sel_S_AXI_awvalid = 1'b1; bus.M_AXI_awready = 1'b1;
        #1;
        checks++;
        if (bus.M_AXI_awvalid !== 1'b0 || bus.Sel_S_AXI_awready !== 1'b0) begin
            errors++;
            $display("FAIL full_gate: awvalid=%b awready=%b expected 0/0", bus.M_AXI_awvalid, bus.Sel_S_AXI_awready);
        end
        // Pop while full: the 5th AW must still be held this cycle.
        exp = sb.pop_front();
        bus.M_AXI_bvalid = 1'b1; bus.M_AXI_bresp = 2'b01;
        bus.S00_AXI_bready = 1'b1; bus.S01_AXI_bready = 1'b1;
        #1;
        checks++;
        if (bus.M_AXI_awvalid !== 1'b0 || bus.M_AXI_bready !== 1'b1 ||
            (exp ? bus.S01_AXI_bvalid : bus.S00_AXI_bvalid) !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_cycle: awvalid=%b bready=%b owner=%0d expected 0/1", bus.M_AXI_awvalid, bus.M_AXI_bready, exp);
        end
        @(posedge ACLK); @(negedge ACLK);
        bus.M_AXI_bvalid = 1'b0;
        #1;
        checks++;
        if (bus.M_AXI_awvalid !== 1'b1 || bus.Outstanding_cnt !== 3'd3) begin
            errors++;
            $display("FAIL full_release: awvalid=%b cnt=%0d expected 1/3", bus.M_AXI_awvalid, bus.Outstanding_cnt);
        end
        @(posedge ACLK); @(negedge ACLK);
        idle_inputs();
        sb.push_back(1'b1);
        checks++;
        if (bus.Outstanding_cnt !== 3'd4) begin
            errors++;
            $display("FAIL full_refill_cnt: got %0d expected 4", bus.Outstanding_cnt);
        end
        for (int i = 0; i < 4; i++) check_b($sformatf("full_drain%0d", i), 2'(i));
    endtask

    task automatic test_back_to_back();
        logic exp, m;
        logic [1:0] resp;
        drive_aw(1'b0);
        drive_aw(1'b1);
        for (int i = 0; i < 10; i++) begin
            m    = logic'($urandom_range(0, 1));
            resp = 2'($urandom_range(0, 3));
            exp  = sb.pop_front();
            bus.Selected_Slave = m; bus.Sel_S_AXI_awvalid = 1'b1; bus.M_AXI_awready = 1'b1;
            bus.M_AXI_bvalid = 1'b1; bus.M_AXI_bresp = resp;
            bus.S00_AXI_bready = 1'b1; bus.S01_AXI_bready = 1'b1;
            #1;
            checks++;
            if ((exp ? bus.S01_AXI_bvalid : bus.S00_AXI_bvalid) !== 1'b1 ||
                (exp ? bus.S00_AXI_bvalid : bus.S01_AXI_bvalid) !== 1'b0 ||
                (exp ? bus.S01_AXI_bresp : bus.S00_AXI_bresp) !== resp || bus.M_AXI_awvalid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_route%0d: v0=%b v1=%b r0=%b r1=%b aw=%b owner=%0d resp=%b", i,
                         bus.S00_AXI_bvalid, bus.S01_AXI_bvalid, bus.S00_AXI_bresp, bus.S01_AXI_bresp,
                         bus.M_AXI_awvalid, exp, resp);
            end
            @(posedge ACLK); @(negedge ACLK);
            sb.push_back(m);
            checks++;
            if (bus.Outstanding_cnt !== 3'd2) begin
                errors++;
                $display("FAIL b2b_cnt%0d: got %0d expected 2", i, bus.Outstanding_cnt);
            end
        end
        idle_inputs();
        check_b("b2b_drain0", 2'b10);
        check_b("b2b_drain1", 2'b01);
    endtask

    task automatic test_backpressure();
        drive_aw(1'b1);
        bus.M_AXI_bvalid = 1'b1; bus.M_AXI_bresp = 2'b10;
        bus.S00_AXI_bready = 1'b1; bus.S01_AXI_bready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.M_AXI_bready !== 1'b0 || bus.S01_AXI_bvalid !== 1'b1 || bus.Outstanding_cnt !== 3'd1) begin
                errors++;
                $display("FAIL bp_hold%0d: bready=%b v1=%b cnt=%0d expected 0/1/1", i,
                         bus.M_AXI_bready, bus.S01_AXI_bvalid, bus.Outstanding_cnt);
            end
            @(posedge ACLK); @(negedge ACLK);
        end
        bus.S01_AXI_bready = 1'b1;
        #1;
        checks++;
        if (bus.M_AXI_bready !== 1'b1 || bus.S01_AXI_bresp !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: bready=%b r1=%b expected 1/10", bus.M_AXI_bready, bus.S01_AXI_bresp);
        end
        @(posedge ACLK); @(negedge ACLK);
        idle_inputs();
        void'(sb.pop_front());
        checks++;
        if (bus.Outstanding_cnt !== 3'd0) begin
            errors++;
            $display("FAIL bp_cnt: got %0d expected 0", bus.Outstanding_cnt);
        end
    endtask

    task automatic test_unexpected_reset();
        bus.M_AXI_bvalid = 1'b1; bus.S00_AXI_bready = 1'b1; bus.S01_AXI_bready = 1'b1;
        #1;
        checks++;
        if (bus.M_AXI_bready !== 1'b0 || bus.Resp_unexpected !== 1'b0) begin
            errors++;
            $display("FAIL unexp_cycle: bready=%b unexp=%b expected 0/0", bus.M_AXI_bready, bus.Resp_unexpected);
        end
        @(posedge ACLK); @(negedge ACLK);
        idle_inputs();
        checks++;
        if (bus.Resp_unexpected !== 1'b1 || bus.Outstanding_cnt !== 3'd0) begin
            errors++;
            $display("FAIL unexp_flag: unexp=%b cnt=%0d expected 1/0", bus.Resp_unexpected, bus.Outstanding_cnt);
        end
        drive_aw(1'b0); drive_aw(1'b1); drive_aw(1'b0);
        checks++;
        if (bus.Outstanding_cnt !== 3'd3 || bus.Resp_unexpected !== 1'b1) begin
            errors++;
            $display("FAIL unexp_sticky: cnt=%0d unexp=%b expected 3/1", bus.Outstanding_cnt, bus.Resp_unexpected);
        end
        bus.M_AXI_bvalid = 1'b1; bus.S00_AXI_bready = 1'b1; bus.S01_AXI_bready = 1'b1;
        #2;
        ARESET = 1'b1;
        #1;
        checks++;
        if (bus.Outstanding_cnt !== 3'd0 || bus.Resp_unexpected !== 1'b0 || bus.S00_AXI_bvalid !== 1'b0 ||
            bus.S01_AXI_bvalid !== 1'b0 || bus.M_AXI_bready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d unexp=%b v0=%b v1=%b bready=%b expected all 0", bus.Outstanding_cnt,
                     bus.Resp_unexpected, bus.S00_AXI_bvalid, bus.S01_AXI_bvalid, bus.M_AXI_bready);
        end
        idle_inputs();
        sb.delete();
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_full();
        test_back_to_back();
        test_backpressure();
        test_unexpected_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
